// File: rtl/demux_wr_dispatch.sv
// Buffered write dispatcher feeding the demux select/data inputs.
// Queues (sel, data) requests and issues one registered strobe per cycle.
module demux_wr_dispatch #(
    parameter int NUM_ELEM   = 6,
    parameter int ELEM_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                         clk_i,
    input  logic                         arst_i,
    input  logic [$clog2(NUM_ELEM)-1:0]  sel_i,
    input  logic [ELEM_WIDTH-1:0]        data_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    input  logic                         stall_i,
    output logic [$clog2(NUM_ELEM)-1:0]  s_o,
    output logic [ELEM_WIDTH-1:0]        d_o,
    output logic [NUM_ELEM-1:0]          we_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         err_o
);

    localparam int SW = $clog2(NUM_ELEM);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [SW-1:0]         sel_mem [DEPTH];
    logic [ELEM_WIDTH-1:0] dat_mem [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic accept;
    logic in_range;
    logic push;
    logic pop;

    // Ready depends only on registered occupancy and the reset pin.
    assign ready_o  = !arst_i && (count < CW'(DEPTH));
    assign in_range = {1'b0, sel_i} < (SW+1)'(NUM_ELEM);
    assign accept   = valid_i && ready_o;
    assign push     = accept && in_range;
    assign pop      = (count != '0) && !stall_i;
    assign count_o  = count;

    always_ff @(posedge clk_i) begin
        if (push) begin
            sel_mem[wr_ptr] <= sel_i;
            dat_mem[wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            s_o  <= '0;
            d_o  <= '0;
            we_o <= '0;
        end else if (pop) begin
            s_o  <= sel_mem[rd_ptr];
            d_o  <= dat_mem[rd_ptr];
            we_o <= NUM_ELEM'(1) << sel_mem[rd_ptr];
        end else begin
            we_o <= '0;
        end
    end

    // Out-of-range requests are swallowed but remembered until reset.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            err_o <= 1'b0;
        end else if (accept && !in_range) begin
            err_o <= 1'b1;
        end
    end

endmodule
